// File: rtl/tinker_cpu_core.sv
// Single-cycle 64-bit Tinker core with 32 GPRs and unified byte-addressed little-endian memory.
// Optional mul/div opcodes are enabled by defining TINKER_MULDIV_EN.
module tinker_cpu_core #(
  parameter int          MEM_BYTES = 524288,
  parameter logic [63:0] RESET_PC  = 64'h2000
) (
  input  logic clk,
  input  logic reset,
  output logic hlt
);

  localparam int AW = $clog2(MEM_BYTES);

  localparam logic [4:0] OP_AND    = 5'h00;
  localparam logic [4:0] OP_OR     = 5'h01;
  localparam logic [4:0] OP_XOR    = 5'h02;
  localparam logic [4:0] OP_NOT    = 5'h03;
  localparam logic [4:0] OP_SHFTR  = 5'h04;
  localparam logic [4:0] OP_SHFTRI = 5'h05;
  localparam logic [4:0] OP_SHFTL  = 5'h06;
  localparam logic [4:0] OP_SHFTLI = 5'h07;
  localparam logic [4:0] OP_BR     = 5'h08;
  localparam logic [4:0] OP_BRR    = 5'h09;
  localparam logic [4:0] OP_BRRI   = 5'h0a;
  localparam logic [4:0] OP_BRNZ   = 5'h0b;
  localparam logic [4:0] OP_CALL   = 5'h0c;
  localparam logic [4:0] OP_RET    = 5'h0d;
  localparam logic [4:0] OP_BRGT   = 5'h0e;
  localparam logic [4:0] OP_PRIV   = 5'h0f;
  localparam logic [4:0] OP_LD     = 5'h10;
  localparam logic [4:0] OP_MOVR   = 5'h11;
  localparam logic [4:0] OP_MOVL   = 5'h12;
  localparam logic [4:0] OP_ST     = 5'h13;
  localparam logic [4:0] OP_ADD    = 5'h18;
  localparam logic [4:0] OP_ADDI   = 5'h19;
  localparam logic [4:0] OP_SUB    = 5'h1a;
  localparam logic [4:0] OP_SUBI   = 5'h1b;
`ifdef TINKER_MULDIV_EN
  localparam logic [4:0] OP_MUL    = 5'h1c;
  localparam logic [4:0] OP_DIV    = 5'h1d;
`endif

  logic [7:0]  mem  [MEM_BYTES];
  logic [63:0] regs [32];
  logic [63:0] pc;

  function automatic logic [AW-1:0] wrap(input logic [63:0] addr);
    return AW'(addr % 64'(MEM_BYTES));
  endfunction

  logic [31:0] instr;
  logic [4:0]  op, rd, rs, rt;
  logic [63:0] sl, lz;
  logic [63:0] rd_v, rs_v, rt_v, r31_m8;
  logic [63:0] ld_addr, ld_data;

  always_comb begin
    instr = '0;
    for (int i = 0; i < 4; i++) instr[8*i +: 8] = mem[wrap(pc + 64'(i))];
  end

  assign op     = instr[31:27];
  assign rd     = instr[26:22];
  assign rs     = instr[21:17];
  assign rt     = instr[16:12];
  assign sl     = {{52{instr[11]}}, instr[11:0]};
  assign lz     = {52'b0, instr[11:0]};
  assign rd_v   = regs[rd];
  assign rs_v   = regs[rs];
  assign rt_v   = regs[rt];
  assign r31_m8 = regs[31] - 64'd8;

  // One read port serves both loads and the return-address fetch.
  assign ld_addr = (op == OP_RET) ? r31_m8 : rs_v + sl;

  always_comb begin
    ld_data = '0;
    for (int i = 0; i < 8; i++) ld_data[8*i +: 8] = mem[wrap(ld_addr + 64'(i))];
  end

  logic [63:0] next_pc, reg_wd, st_addr, st_data;
  logic        reg_we, mem_we, halt_now;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    next_pc  = pc + 64'd4;
    reg_we   = 1'b0;
    reg_wd   = '0;
    mem_we   = 1'b0;
    st_addr  = rd_v + sl;
    st_data  = rs_v;
    halt_now = 1'b0;
    case (op)
      OP_AND:    begin reg_we = 1'b1; reg_wd = rs_v & rt_v;        end
      OP_OR:     begin reg_we = 1'b1; reg_wd = rs_v | rt_v;        end
      OP_XOR:    begin reg_we = 1'b1; reg_wd = rs_v ^ rt_v;        end
      OP_NOT:    begin reg_we = 1'b1; reg_wd = ~rs_v;              end
      OP_SHFTR:  begin reg_we = 1'b1; reg_wd = rs_v >> rt_v[5:0];  end
      OP_SHFTRI: begin reg_we = 1'b1; reg_wd = rd_v >> lz;         end
      OP_SHFTL:  begin reg_we = 1'b1; reg_wd = rs_v << rt_v[5:0];  end
      OP_SHFTLI: begin reg_we = 1'b1; reg_wd = rd_v << lz;         end
      OP_ADD:    begin reg_we = 1'b1; reg_wd = rs_v + rt_v;        end
      OP_ADDI:   begin reg_we = 1'b1; reg_wd = rd_v + lz;          end
      OP_SUB:    begin reg_we = 1'b1; reg_wd = rs_v - rt_v;        end
      OP_SUBI:   begin reg_we = 1'b1; reg_wd = rd_v - lz;          end
`ifdef TINKER_MULDIV_EN
      OP_MUL:    begin reg_we = 1'b1; reg_wd = rs_v * rt_v;        end
      OP_DIV:    begin
        reg_we = 1'b1;
        reg_wd = (rt_v == '0) ? '0 : rs_v / rt_v;
      end
`endif
      OP_BR:     next_pc = rd_v;
      OP_BRR:    next_pc = pc + rd_v;
      OP_BRRI:   next_pc = pc + sl;
      OP_BRNZ:   if (rs_v != '0) next_pc = rd_v;
      OP_BRGT:   if ($signed(rs_v) > $signed(rt_v)) next_pc = rd_v;
      OP_CALL: begin
        mem_we  = 1'b1;
        st_addr = r31_m8;
        st_data = pc + 64'd4;
        next_pc = rd_v;
      end
      OP_RET:    next_pc = ld_data;
      OP_LD:     begin reg_we = 1'b1; reg_wd = ld_data;                   end
      OP_MOVR:   begin reg_we = 1'b1; reg_wd = rs_v;                      end
      OP_MOVL:   begin reg_we = 1'b1; reg_wd = {rd_v[63:12], instr[11:0]}; end
      OP_ST:     mem_we = 1'b1;
      // Any priv (L==0 halt, L!=0 illegal), float op or undefined opcode stops the core.
      OP_PRIV:   halt_now = 1'b1;
      default:   halt_now = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc  <= RESET_PC;
      hlt <= 1'b0;
      for (int i = 0; i < 31; i++) regs[i] <= '0;
      regs[31] <= 64'(MEM_BYTES);
    end else if (!hlt) begin
      // NOTE: state is updated with non-blocking assignments so every read in this cycle sees pre-edge values.
      if (halt_now) begin
        hlt <= 1'b1;
      end else begin
        pc <= next_pc;
        if (reg_we) regs[rd] <= reg_wd;
      end
    end
  end

  // NOTE: memory is deliberately left out of reset so a preloaded program survives a reset.
  always_ff @(posedge clk) begin
    if (reset && !hlt && mem_we) begin
      for (int i = 0; i < 8; i++) mem[wrap(st_addr + 64'(i))] <= st_data[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_tinker_cpu_core.sv
// Self-checking bench for tinker_cpu_core: small programs preloaded into memory,
// expected register contents queued at load time and compared once the core halts.
module tb_tinker_cpu_core;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hlt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          idx;
    logic [63:0] val;
  } reg_exp_t;

  reg_exp_t sb[$];

  tinker_cpu_core dut (
    .clk   (clk),
    .reset (reset),
    .hlt   (hlt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (time limit reached)");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [11:0] l);
    return {op, rd, rs, rt, l};
  endfunction

  task automatic put(input int addr, input logic [31:0] w);
    for (int i = 0; i < 4; i++) dut.mem[addr + i] <= w[8*i +: 8];
  endtask

  task automatic expect_reg(input int idx, input logic [63:0] val);
    reg_exp_t e;
    e.idx = idx;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_to_halt(input int max, output int cycles);
    cycles = 0;
    while (!hlt && cycles < max) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    put('h2000, enc(5'h0f, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (hlt !== 1'b0) begin n_fail++; $display("FAIL reset_hlt: got %b want 0", hlt); end
    n_checks++;
    if (dut.pc !== 64'h2000) begin n_fail++; $display("FAIL reset_pc: got %h want 2000", dut.pc); end
    n_checks++;
    if (dut.regs[31] !== 64'd524288) begin n_fail++; $display("FAIL reset_r31: got %0d want 524288", dut.regs[31]); end
    n_checks++;
    if (dut.regs[5] !== 64'd0) begin n_fail++; $display("FAIL reset_r5: got %h want 0", dut.regs[5]); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (hlt !== 1'b0) begin n_fail++; $display("FAIL reset_release_hlt: got %b want 0", hlt); end
  endtask

  task automatic test_alu();
    int cycles;
    bit stayed;
    reset = 1'b0;
    put('h2000, enc(5'h12, 1, 0, 0, 5));
    put('h2004, enc(5'h12, 2, 0, 0, 7));
    put('h2008, enc(5'h18, 3, 1, 2, 0));
    put('h200c, enc(5'h1a, 4, 1, 2, 0));
    put('h2010, enc(5'h0f, 0, 0, 0, 0));
    expect_reg(1, 64'd5);
    expect_reg(2, 64'd7);
    expect_reg(3, 64'd12);
    expect_reg(4, 64'hFFFF_FFFF_FFFF_FFFE);
    release_reset();
    run_to_halt(50, cycles);
    n_checks++;
    if (cycles !== 5) begin n_fail++; $display("FAIL alu_halt_edges: got %0d want 5", cycles); end
    stayed = 1'b1;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (hlt !== 1'b1 || dut.pc !== 64'h2010) stayed = 1'b0;
    end
    n_checks++;
    if (stayed !== 1'b1) begin n_fail++; $display("FAIL alu_halt_sticky: hlt=%b pc=%h want 1/2010", hlt, dut.pc); end
    while (sb.size() > 0) begin
      reg_exp_t e = sb.pop_front();
      n_checks++;
      if (dut.regs[e.idx] !== e.val) begin n_fail++; $display("FAIL alu_r%0d: got %h want %h", e.idx, dut.regs[e.idx], e.val); end
    end
  endtask

  task automatic test_logic();
    int cycles;
    logic [31:0] p[$];
    reset = 1'b0;
    p = '{enc(5'h12, 1, 0, 0, 12'hABC), enc(5'h12, 2, 0, 0, 12'h0F0),
          enc(5'h00, 3, 1, 2, 0),       enc(5'h01, 4, 1, 2, 0),
          enc(5'h02, 5, 1, 2, 0),       enc(5'h03, 6, 1, 0, 0),
          enc(5'h07, 1, 0, 0, 52),      enc(5'h12, 8, 0, 0, 4),
          enc(5'h04, 9, 1, 8, 0),       enc(5'h06, 10, 2, 8, 0),
          enc(5'h05, 2, 0, 0, 4),       enc(5'h19, 3, 0, 0, 12'hFFF),
          enc(5'h1b, 4, 0, 0, 12'hFFF), enc(5'h11, 12, 6, 0, 0),
          enc(5'h12, 12, 0, 0, 12'h123), enc(5'h18, 13, 6, 6, 0),
          enc(5'h0f, 0, 0, 0, 0)};
    foreach (p[i]) put('h2000 + 4 * i, p[i]);
    expect_reg(1,  64'hABC0_0000_0000_0000);
    expect_reg(2,  64'h0000_0000_0000_000F);
    expect_reg(3,  64'h0000_0000_0000_10AF);
    expect_reg(4,  64'hFFFF_FFFF_FFFF_FAFD);
    expect_reg(5,  64'h0000_0000_0000_0A4C);
    expect_reg(6,  64'hFFFF_FFFF_FFFF_F543);
    expect_reg(9,  64'h0ABC_0000_0000_0000);
    expect_reg(10, 64'h0000_0000_0000_0F00);
    expect_reg(12, 64'hFFFF_FFFF_FFFF_F123);
    expect_reg(13, 64'hFFFF_FFFF_FFFF_EA86);
    release_reset();
    run_to_halt(100, cycles);
    n_checks++;
    if (cycles !== 17) begin n_fail++; $display("FAIL logic_halt_edges: got %0d want 17", cycles); end
    while (sb.size() > 0) begin
      reg_exp_t e = sb.pop_front();
      n_checks++;
      if (dut.regs[e.idx] !== e.val) begin n_fail++; $display("FAIL logic_r%0d: got %h want %h", e.idx, dut.regs[e.idx], e.val); end
    end
  endtask

  task automatic test_memory();
    int cycles;
    logic [31:0] p[$];
    logic [11:0] chunks[5];
    reset = 1'b0;
    chunks = '{12'h122, 12'h334, 12'h455, 12'h667, 12'h788};
    p = '{enc(5'h12, 1, 0, 0, 3), enc(5'h07, 1, 0, 0, 12), enc(5'h12, 2, 0, 0, 1)};
    foreach (chunks[i]) begin
      p.push_back(enc(5'h07, 2, 0, 0, 12));
      p.push_back(enc(5'h12, 2, 0, 0, chunks[i]));
    end
    p.push_back(enc(5'h13, 1, 2, 0, 8));
    p.push_back(enc(5'h10, 3, 1, 0, 8));
    p.push_back(enc(5'h13, 5, 2, 0, 12'hFFD));
    p.push_back(enc(5'h10, 6, 5, 0, 12'hFFD));
    p.push_back(enc(5'h0f, 0, 0, 0, 0));
    foreach (p[i]) put('h2000 + 4 * i, p[i]);
    expect_reg(1, 64'h3000);
    expect_reg(2, 64'h1122_3344_5566_7788);
    expect_reg(3, 64'h1122_3344_5566_7788);
    expect_reg(6, 64'h1122_3344_5566_7788);
    release_reset();
    run_to_halt(100, cycles);
    n_checks++;
    if (cycles !== 18) begin n_fail++; $display("FAIL mem_halt_edges: got %0d want 18", cycles); end
    while (sb.size() > 0) begin
      reg_exp_t e = sb.pop_front();
      n_checks++;
      if (dut.regs[e.idx] !== e.val) begin n_fail++; $display("FAIL mem_r%0d: got %h want %h", e.idx, dut.regs[e.idx], e.val); end
    end
    n_checks++;
    if (dut.mem['h3008] !== 8'h88) begin n_fail++; $display("FAIL mem_byte_3008: got %h want 88", dut.mem['h3008]); end
    n_checks++;
    if (dut.mem['h300F] !== 8'h11) begin n_fail++; $display("FAIL mem_byte_300F: got %h want 11", dut.mem['h300F]); end
    n_checks++;
    if (dut.mem['h7FFFD] !== 8'h88) begin n_fail++; $display("FAIL mem_wrap_7FFFD: got %h want 88", dut.mem['h7FFFD]); end
    n_checks++;
    if (dut.mem[4] !== 8'h11) begin n_fail++; $display("FAIL mem_wrap_0004: got %h want 11", dut.mem[4]); end
  endtask

  task automatic test_branch();
    int cycles;
    logic [63:0] ret;
    reset = 1'b0;
    put('h2000, enc(5'h12, 1, 0, 0, 1));
    put('h2004, enc(5'h12, 12, 0, 0, 12'h204));
    put('h2008, enc(5'h07, 12, 0, 0, 4));
    put('h200c, enc(5'h12, 10, 0, 0, 12'h021));
    put('h2010, enc(5'h07, 10, 0, 0, 8));
    put('h2014, enc(5'h0b, 12, 2, 0, 0));
    put('h2018, enc(5'h12, 20, 0, 0, 12'h111));
    put('h201c, enc(5'h0b, 12, 1, 0, 0));
    put('h2020, enc(5'h12, 21, 0, 0, 12'hBAD));
    put('h2040, enc(5'h12, 22, 0, 0, 12'h222));
    put('h2044, enc(5'h0c, 10, 0, 0, 0));
    put('h2048, enc(5'h12, 23, 0, 0, 12'h333));
    put('h204c, enc(5'h03, 4, 0, 0, 0));
    put('h2050, enc(5'h0e, 12, 4, 1, 0));
    put('h2054, enc(5'h12, 24, 0, 0, 12'h444));
    put('h2058, enc(5'h0a, 0, 0, 0, 8));
    put('h205c, enc(5'h12, 25, 0, 0, 12'hBAD));
    put('h2060, enc(5'h12, 13, 0, 0, 12'h010));
    put('h2064, enc(5'h09, 13, 0, 0, 0));
    put('h2068, enc(5'h12, 25, 0, 0, 12'hBAD));
    put('h2074, enc(5'h0f, 0, 0, 0, 0));
    put('h2100, enc(5'h12, 26, 0, 0, 12'h555));
    put('h2104, enc(5'h0d, 0, 0, 0, 0));
    expect_reg(4,  64'hFFFF_FFFF_FFFF_FFFF);
    expect_reg(20, 64'h111);
    expect_reg(21, 64'h0);
    expect_reg(22, 64'h222);
    expect_reg(23, 64'h333);
    expect_reg(24, 64'h444);
    expect_reg(25, 64'h0);
    expect_reg(26, 64'h555);
    expect_reg(31, 64'h8_0000);
    release_reset();
    run_to_halt(100, cycles);
    n_checks++;
    if (dut.pc !== 64'h2074) begin n_fail++; $display("FAIL br_final_pc: got %h want 2074 (cycles %0d)", dut.pc, cycles); end
    while (sb.size() > 0) begin
      reg_exp_t e = sb.pop_front();
      n_checks++;
      if (dut.regs[e.idx] !== e.val) begin n_fail++; $display("FAIL br_r%0d: got %h want %h", e.idx, dut.regs[e.idx], e.val); end
    end
    for (int i = 0; i < 8; i++) ret[8*i +: 8] = dut.mem['h7FFF8 + i];
    n_checks++;
    if (ret !== 64'h2048) begin n_fail++; $display("FAIL br_call_return_slot: got %h want 2048", ret); end
  endtask

  task automatic test_illegal();
    int cycles;
    reset = 1'b0;
    put('h2000, enc(5'h14, 1, 31, 31, 0));
    for (int i = 0; i < 31; i++) expect_reg(i, 64'h0);
    expect_reg(31, 64'd524288);
    release_reset();
    run_to_halt(20, cycles);
    n_checks++;
    if (cycles !== 1) begin n_fail++; $display("FAIL ill_float_edges: got %0d want 1", cycles); end
    n_checks++;
    if (dut.pc !== 64'h2000) begin n_fail++; $display("FAIL ill_float_pc: got %h want 2000", dut.pc); end
    while (sb.size() > 0) begin
      reg_exp_t e = sb.pop_front();
      n_checks++;
      if (dut.regs[e.idx] !== e.val) begin n_fail++; $display("FAIL ill_r%0d: got %h want %h", e.idx, dut.regs[e.idx], e.val); end
    end

    reset = 1'b0;
    put('h2000, enc(5'h12, 1, 0, 0, 1));
    put('h2004, enc(5'h0f, 2, 0, 0, 5));
    put('h2008, enc(5'h12, 2, 0, 0, 1));
    expect_reg(1, 64'd1);
    expect_reg(2, 64'd0);
    release_reset();
    run_to_halt(20, cycles);
    n_checks++;
    if (dut.pc !== 64'h2004) begin n_fail++; $display("FAIL ill_priv_pc: got %h want 2004 (cycles %0d)", dut.pc, cycles); end
    while (sb.size() > 0) begin
      reg_exp_t e = sb.pop_front();
      n_checks++;
      if (dut.regs[e.idx] !== e.val) begin n_fail++; $display("FAIL ill_priv_r%0d: got %h want %h", e.idx, dut.regs[e.idx], e.val); end
    end
  endtask

  task automatic test_muldiv();
    int cycles;
    logic [63:0] exp_pc;
    reset = 1'b0;
    put('h2000, enc(5'h12, 1, 0, 0, 6));
    put('h2004, enc(5'h12, 2, 0, 0, 7));
    put('h2008, enc(5'h1c, 3, 1, 2, 0));
    put('h200c, enc(5'h1d, 4, 2, 0, 0));
    put('h2010, enc(5'h1d, 6, 3, 2, 0));
    put('h2014, enc(5'h12, 5, 0, 0, 1));
    put('h2018, enc(5'h0f, 0, 0, 0, 0));
`ifdef TINKER_MULDIV_EN
    exp_pc = 64'h2018;
    expect_reg(3, 64'd42);
    expect_reg(4, 64'd0);
    expect_reg(6, 64'd6);
    expect_reg(5, 64'd1);
`else
    exp_pc = 64'h2008;
    expect_reg(3, 64'd0);
    expect_reg(6, 64'd0);
    expect_reg(5, 64'd0);
`endif
    release_reset();
    run_to_halt(50, cycles);
    n_checks++;
    if (dut.pc !== exp_pc) begin n_fail++; $display("FAIL muldiv_pc: got %h want %h (cycles %0d)", dut.pc, exp_pc, cycles); end
    while (sb.size() > 0) begin
      reg_exp_t e = sb.pop_front();
      n_checks++;
      if (dut.regs[e.idx] !== e.val) begin n_fail++; $display("FAIL muldiv_r%0d: got %h want %h", e.idx, dut.regs[e.idx], e.val); end
    end
  endtask

  task automatic test_async_reset();
    int cycles;
    reset = 1'b0;
    put('h2000, enc(5'h19, 1, 0, 0, 1));
    put('h2004, enc(5'h0a, 0, 0, 0, 12'hFFC));
    release_reset();
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (dut.regs[1] !== 64'd5) begin n_fail++; $display("FAIL async_loop_count: got %0d want 5", dut.regs[1]); end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (dut.pc !== 64'h2000) begin n_fail++; $display("FAIL async_pc: got %h want 2000", dut.pc); end
    n_checks++;
    if (dut.regs[1] !== 64'd0) begin n_fail++; $display("FAIL async_r1: got %h want 0", dut.regs[1]); end
    n_checks++;
    if (dut.mem['h2000] !== 8'h01) begin n_fail++; $display("FAIL async_mem_kept: got %h want 01", dut.mem['h2000]); end

    put('h2000, enc(5'h0f, 0, 0, 0, 0));
    release_reset();
    run_to_halt(20, cycles);
    n_checks++;
    if (hlt !== 1'b1) begin n_fail++; $display("FAIL async_pre_halt: got %b want 1 (cycles %0d)", hlt, cycles); end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (hlt !== 1'b0) begin n_fail++; $display("FAIL async_hlt_clear: got %b want 0", hlt); end
    release_reset();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_logic();
    test_memory();
    test_branch();
    test_illegal();
    test_muldiv();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
